// File: rtl/sort.sv
// Packet sorter: stores one Avalon-ST packet, bubble-sorts it in place
// (ascending, unsigned, stable), then streams it out as a single packet.
module sort #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 1024
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    input  logic              src_ready_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o
);
    localparam int unsigned AW = $clog2(MAX_PKT_LEN);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {IDLE, RECV, SORT, FLUSH, SEND} state_t;

    state_t            state;
    logic [CW-1:0]     len;
    logic [CW-1:0]     last;
    logic [CW-1:0]     ridx;
    logic [CW-1:0]     cidx;
    logic [CW-1:0]     sidx;
    logic [DWIDTH-1:0] cur;
    logic              rd_vld;

    logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
    logic [DWIDTH-1:0] rd_q;

    logic              store_c;
    logic [CW-1:0]     len_nxt_c;
    logic              we_c;
    logic [AW-1:0]     wr_addr_c;
    logic [DWIDTH-1:0] wr_data_c;
    logic              rd_en_c;
    logic [AW-1:0]     rd_addr_c;
    logic [DWIDTH-1:0] min_c;
    logic [DWIDTH-1:0] max_c;

    // The RAM read register doubles as the output data register.
    assign src_data_o = rd_q;

    always_comb begin
        store_c   = snk_valid_i && snk_ready_o &&
                    ((state == RECV) || ((state == IDLE) && snk_startofpacket_i));
        len_nxt_c = snk_startofpacket_i ? CW'(1) : len + CW'(1);
        min_c     = (cur > rd_q) ? rd_q : cur;
        max_c     = (cur > rd_q) ? cur : rd_q;
    end

    // RAM port control; a pass carries the running maximum in cur and
    // writes the smaller value one slot behind the read pointer.
    always_comb begin
        we_c      = 1'b0;
        wr_addr_c = '0;
        wr_data_c = snk_data_i;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        case (state)
            IDLE, RECV: begin
                we_c      = store_c;
                wr_addr_c = snk_startofpacket_i ? '0 : len[AW-1:0];
            end
            SORT: begin
                rd_en_c   = (last != '0) && (ridx <= last);
                rd_addr_c = ridx[AW-1:0];
                if (rd_vld && (cidx != '0)) begin
                    we_c      = 1'b1;
                    wr_addr_c = AW'(cidx - CW'(1));
                    wr_data_c = min_c;
                end
            end
            FLUSH: begin
                we_c      = 1'b1;
                wr_addr_c = last[AW-1:0];
                wr_data_c = cur;
            end
            SEND: begin
                rd_en_c   = !src_valid_o || (src_ready_i && !src_endofpacket_o);
                rd_addr_c = sidx[AW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (we_c) mem[wr_addr_c] <= wr_data_c;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i)       rd_q <= '0;
        else if (rd_en_c) rd_q <= mem[rd_addr_c];
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state               <= IDLE;
            len                 <= '0;
            last                <= '0;
            ridx                <= '0;
            cidx                <= '0;
            sidx                <= '0;
            cur                 <= '0;
            rd_vld              <= 1'b0;
            snk_ready_o         <= 1'b0;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
        end else begin
            rd_vld <= rd_en_c;
            case (state)
                IDLE, RECV: begin
                    snk_ready_o <= 1'b1;
                    if (store_c) begin
                        len   <= len_nxt_c;
                        state <= RECV;
                        if (snk_endofpacket_i || (len_nxt_c == CW'(MAX_PKT_LEN))) begin
                            state       <= SORT;
                            snk_ready_o <= 1'b0;
                            last        <= len_nxt_c - CW'(1);
                            ridx        <= '0;
                            cidx        <= '0;
                        end
                    end
                end
                SORT: begin
                    if (last == '0) begin
                        state <= SEND;
                        sidx  <= '0;
                    end else begin
                        if (rd_en_c) ridx <= ridx + CW'(1);
                        if (rd_vld) begin
                            cur  <= (cidx == '0) ? rd_q : max_c;
                            cidx <= cidx + CW'(1);
                            if (cidx == last) state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    ridx <= '0;
                    cidx <= '0;
                    if (last == CW'(1)) begin
                        state <= SEND;
                        sidx  <= '0;
                    end else begin
                        last  <= last - CW'(1);
                        state <= SORT;
                    end
                end
                SEND: begin
                    if (!src_valid_o) begin
                        src_valid_o         <= 1'b1;
                        src_startofpacket_o <= 1'b1;
                        src_endofpacket_o   <= (len == CW'(1));
                        sidx                <= CW'(1);
                    end else if (src_ready_i) begin
                        if (src_endofpacket_o) begin
                            src_valid_o         <= 1'b0;
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= 1'b0;
                            snk_ready_o         <= 1'b1;
                            len                 <= '0;
                            state               <= IDLE;
                        end else begin
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= (sidx == len - CW'(1));
                            sidx                <= sidx + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort.sv
// Self-checking bench for sort: a counting-sort reference model feeds a
// per-cycle output checker; directed packets cover the listed scenarios.
module tb_sort;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXL = 32;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic [DW-1:0] snk_data_i;
    logic          snk_startofpacket_i;
    logic          snk_endofpacket_i;
    logic          snk_valid_i;
    logic          src_ready_i;
    logic          snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;

    sort #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
        .clk_i              (clk_i),
        .srst_i             (srst_i),
        .snk_data_i         (snk_data_i),
        .snk_startofpacket_i(snk_startofpacket_i),
        .snk_endofpacket_i  (snk_endofpacket_i),
        .snk_valid_i        (snk_valid_i),
        .src_ready_i        (src_ready_i),
        .snk_ready_o        (snk_ready_o),
        .src_data_o         (src_data_o),
        .src_startofpacket_o(src_startofpacket_o),
        .src_endofpacket_o  (src_endofpacket_o),
        .src_valid_o        (src_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_data[$];
    int            exp_len[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] pkt[$];
    logic [DW-1:0] lit[$];
    bit            rdy_rand = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: keep the first MAXL words, emit them in ascending order by
    // scanning every possible value and copying each match.
    function automatic void model_push();
        int n;
        n = (pkt.size() > MAXL) ? MAXL : pkt.size();
        for (int v = 0; v < (1 << DW); v++)
            for (int i = 0; i < n; i++)
                if (int'(pkt[i]) == v) exp_data.push_back(pkt[i]);
        exp_len.push_back(n);
    endfunction

    function automatic void set_lit(input logic [63:0] v, input int n);
        lit.delete();
        for (int i = 0; i < n; i++) lit.push_back(v[8*(n-1-i) +: 8]);
    endfunction

    // Output checker, sampled mid-cycle.
    int            idx   = 0;
    bit            stall = 1'b0;
    bit            moved = 1'b0;
    logic [DW-1:0] pd;
    logic          ps, pe;
    logic [DW-1:0] ew;
    always @(negedge clk_i) begin
        if (srst_i) begin
            idx = 0; stall = 1'b0; moved = 1'b0;
        end else begin
            if (moved) chk("throughput_valid", longint'(src_valid_o), 1);
            moved = 1'b0;
            if (src_valid_o) begin
                if (stall) begin
                    chk("hold_data", longint'(src_data_o), longint'(pd));
                    chk("hold_sop", longint'(src_startofpacket_o), longint'(ps));
                    chk("hold_eop", longint'(src_endofpacket_o), longint'(pe));
                end
                if (src_ready_i) begin
                    if (exp_len.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %0d, expected no output", src_data_o);
                    end else begin
                        ew = exp_data.pop_front();
                        chk("data", longint'(src_data_o), longint'(ew));
                        chk("sop", longint'(src_startofpacket_o), longint'(idx == 0));
                        chk("eop", longint'(src_endofpacket_o), longint'(idx == exp_len[0] - 1));
                        got.push_back(src_data_o);
                        idx++;
                        if (idx == exp_len[0]) begin
                            void'(exp_len.pop_front());
                            idx = 0;
                        end else begin
                            moved = !rdy_rand;
                        end
                    end
                end
                stall = !src_ready_i;
                pd = src_data_o; ps = src_startofpacket_o; pe = src_endofpacket_o;
            end else begin
                chk("idle_flags", longint'({src_startofpacket_o, src_endofpacket_o}), 0);
                stall = 1'b0;
            end
        end
    end

    initial begin
        src_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            src_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic beat(input logic [DW-1:0] d, input bit sop, input bit eop, input int gap);
        bit rdy;
        int n;
        repeat (gap) begin
            snk_valid_i = 1'b0; snk_startofpacket_i = sop; snk_endofpacket_i = 1'b0;
            @(posedge clk_i); #1;
        end
        snk_data_i = d; snk_startofpacket_i = sop; snk_endofpacket_i = eop; snk_valid_i = 1'b1;
        n = 0;
        forever begin
            rdy = snk_ready_o;
            @(posedge clk_i); #1;
            if (rdy) break;
            n++;
            if (n > 4000) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no snk_ready_o, expected it within 4000 cycles");
                break;
            end
        end
    endtask

    task automatic send_pkt(input bit gaps);
        for (int i = 0; i < pkt.size(); i++)
            beat(pkt[i], i == 0, i == pkt.size() - 1, gaps ? int'($urandom_range(0, 2)) : 0);
        snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
        model_push();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_len.size() != 0 || src_valid_o) begin
            @(posedge clk_i); #1;
            n++;
            if (n > budget) begin
                checks++; errors++;
                $display("FAIL drain_timeout: got %0d packets pending, expected 0 after %0d cycles",
                         exp_len.size(), budget);
                break;
            end
        end
        chk("ready_after_send", longint'(snk_ready_o), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!src_valid_o) begin
            @(posedge clk_i); #1;
            n++;
            if (n > budget) begin
                checks++; errors++;
                $display("FAIL valid_timeout: got no src_valid_o, expected it within %0d cycles", budget);
                break;
            end
        end
    endtask

    task automatic chk_pkt(input string name);
        chk({name, "_len"}, longint'(got.size()), longint'(lit.size()));
        for (int i = 0; i < lit.size() && i < got.size(); i++)
            chk({name, "_word"}, longint'(got[i]), longint'(lit[i]));
        got.delete();
    endtask

    task automatic reset_pulse(input string name);
        srst_i = 1'b1;
        snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
        exp_data.delete(); exp_len.delete(); got.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        chk({name, "_snk_ready"}, longint'(snk_ready_o), 0);
        chk({name, "_valid"}, longint'(src_valid_o), 0);
        chk({name, "_sop"}, longint'(src_startofpacket_o), 0);
        chk({name, "_eop"}, longint'(src_endofpacket_o), 0);
        chk({name, "_data"}, longint'(src_data_o), 0);
        @(posedge clk_i); #1;
        srst_i = 1'b0;
        @(posedge clk_i); #1;
        chk({name, "_ready_after"}, longint'(snk_ready_o), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst_i = 1'b1;
        snk_data_i = '0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0; snk_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_pulse("reset");

        // 10 random words with input gaps
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(DW'($urandom_range(0, 255)));
        send_pkt(1'b1);
        wait_done(2 * 10 * 10 + 100);
        chk("pkt10_count", longint'(got.size()), 10);
        got.delete();

        // MAXL-1 random words
        pkt.delete();
        for (int i = 0; i < MAXL - 1; i++) pkt.push_back(DW'($urandom_range(0, 255)));
        send_pkt(1'b0);
        wait_done(2 * MAXL * MAXL + 100);
        chk("pkt_long_count", longint'(got.size()), longint'(MAXL - 1));
        got.delete();

        // single word
        pkt.delete();
        pkt.push_back(8'h5A);
        send_pkt(1'b0);
        wait_done(100);
        set_lit(64'h5A, 1);
        chk_pkt("single");

        // duplicates and extremes under random backpressure
        rdy_rand = 1'b1;
        pkt.delete();
        set_lit(64'h03_03_00_FF_01, 5);
        pkt = lit;
        send_pkt(1'b1);
        wait_done(1000);
        set_lit(64'h00_01_03_03_FF, 5);
        chk_pkt("stall");
        rdy_rand = 1'b0;

        // overlong packet without EOP: storage fills and input stalls
        pkt.delete();
        for (int i = 0; i < MAXL + 5; i++) pkt.push_back(DW'($urandom_range(0, 255)));
        for (int i = 0; i < MAXL + 5; i++) begin
            beat(pkt[i], i == 0, 1'b0, 0);
            if (i == MAXL - 1) begin
                chk("full_ready_drop", longint'(snk_ready_o), 0);
                model_push();
            end
        end
        snk_valid_i = 1'b0;
        wait_done(2 * MAXL * MAXL + 100);
        chk("overflow_count", longint'(got.size()), longint'(MAXL));
        got.delete();

        // reset during reception
        beat(8'd11, 1'b1, 1'b0, 0);
        beat(8'd22, 1'b0, 1'b0, 1);
        beat(8'd33, 1'b0, 1'b0, 0);
        reset_pulse("rst_recv");

        // reset during transmission
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back(DW'(60 - 10 * i));
        send_pkt(1'b0);
        wait_valid(200);
        repeat (2) @(posedge clk_i);
        #1;
        reset_pulse("rst_send");

        pkt.delete();
        set_lit(64'h09_02_07_02, 4);
        pkt = lit;
        send_pkt(1'b0);
        wait_done(200);
        set_lit(64'h02_02_07_09, 4);
        chk_pkt("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
